// File: rtl/version_read_scheduler_if.sv
// Handshake bundle for version_read_scheduler: write port, read request port,
// read response port and the busy status flag.
interface version_read_scheduler_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4
) ();
  logic                     wrValid;
  logic                     wrReady;
  logic [VERSION_WIDTH-1:0] wrVersion;
  logic [DATA_WIDTH-1:0]    wrData;

  logic                     rdValid;
  logic                     rdReady;
  logic [VERSION_WIDTH-1:0] rdVersion;

  logic                     respValid;
  logic                     respReady;
  logic                     respHit;
  logic [VERSION_WIDTH-1:0] respVersion;
  logic [DATA_WIDTH-1:0]    respData;

  logic                     busy;

  modport slave (
    input  wrValid, wrVersion, wrData, rdValid, rdVersion, respReady,
    output wrReady, rdReady, respValid, respHit, respVersion, respData, busy
  );

  modport master (
    output wrValid, wrVersion, wrData, rdValid, rdVersion, respReady,
    input  wrReady, rdReady, respValid, respHit, respVersion, respData, busy
  );
endinterface

// File: rtl/version_read_scheduler.sv
// Versioned slot store with alternating write/read arbitration and a sequential
// newest-version-not-above-request scan. Optional `VERSION_SCHED_CLEAR_EN adds a clear input.
module version_read_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic clk,
  input  logic rstN,
`ifdef VERSION_SCHED_CLEAR_EN
  input  logic clear,
`endif
  version_read_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(VERSION_NUM);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_e;
  typedef enum logic       {G_READ, G_WRITE}        grant_e;

  state_e                   state_q, state_d;
  grant_e                   last_grant_q, last_grant_d;
  logic [VERSION_NUM-1:0]   valid_q, valid_d;
  logic [VERSION_WIDTH-1:0] ver_q  [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    data_q [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] req_ver_q, req_ver_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     best_hit_q, best_hit_d;
  logic [VERSION_WIDTH-1:0] best_ver_q, best_ver_d;
  logic [DATA_WIDTH-1:0]    best_data_q, best_data_d;
  logic                     clr_pend_q, clr_pend_d;

  logic                     wr_ready, rd_ready, wr_en, clr_now, scan_cand;
  logic [IDX_W-1:0]         wr_idx;

  // Write target: equal version, else first free slot, else oldest version.
  logic                     eq_found, inv_found, min_found;
  logic [IDX_W-1:0]         eq_idx, inv_idx, min_idx;
  logic [VERSION_WIDTH-1:0] min_ver;

  always_comb begin
    eq_found  = 1'b0;
    inv_found = 1'b0;
    min_found = 1'b0;
    eq_idx    = '0;
    inv_idx   = '0;
    min_idx   = '0;
    min_ver   = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (valid_q[i] && (ver_q[i] == bus.wrVersion) && !eq_found) begin
        eq_found = 1'b1;
        eq_idx   = IDX_W'(i);
      end
      if (!valid_q[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
      if (valid_q[i] && (!min_found || (ver_q[i] < min_ver))) begin
        min_found = 1'b1;
        min_ver   = ver_q[i];
        min_idx   = IDX_W'(i);
      end
    end
    wr_idx = eq_found ? eq_idx : (inv_found ? inv_idx : min_idx);
  end

`ifdef VERSION_SCHED_CLEAR_EN
  assign clr_now = clear || clr_pend_q;
`else
  assign clr_now = 1'b0;
`endif

  assign scan_cand = valid_q[idx_q] && (ver_q[idx_q] <= req_ver_q) &&
                     (!best_hit_q || (ver_q[idx_q] > best_ver_q));

  // NOTE: every variable below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    valid_d      = valid_q;
    req_ver_d    = req_ver_q;
    idx_d        = idx_q;
    best_hit_d   = best_hit_q;
    best_ver_d   = best_ver_q;
    best_data_d  = best_data_q;
    clr_pend_d   = clr_pend_q;
    wr_ready     = 1'b0;
    rd_ready     = 1'b0;
    wr_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clr_now) begin
          valid_d    = '0;
          clr_pend_d = 1'b0;
        end else if (rstN) begin
          // Both requesting: grant whoever did not win last time.
          if (bus.wrValid && (!bus.rdValid || (last_grant_q == G_READ))) begin
            wr_ready = 1'b1;
          end else if (bus.rdValid) begin
            rd_ready = 1'b1;
          end
        end

        if (wr_ready) begin
          wr_en           = 1'b1;
          valid_d[wr_idx] = 1'b1;
          last_grant_d    = G_WRITE;
        end

        if (rd_ready) begin
          req_ver_d    = bus.rdVersion;
          best_hit_d   = 1'b0;
          idx_d        = '0;
          last_grant_d = G_READ;
          state_d      = S_SCAN;
        end
      end

      S_SCAN: begin
        if (scan_cand) begin
          best_hit_d  = 1'b1;
          best_ver_d  = ver_q[idx_q];
          best_data_d = data_q[idx_q];
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(VERSION_NUM - 1)) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.respReady) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef VERSION_SCHED_CLEAR_EN
    // A clear during a read waits so the scan finishes on the pre-clear store.
    if ((state_q != S_IDLE) && clear) begin
      clr_pend_d = 1'b1;
    end
`endif
  end

  // NOTE: control state uses non-blocking assignments under async reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_READ;
      valid_q      <= '0;
      req_ver_q    <= '0;
      idx_q        <= '0;
      best_hit_q   <= 1'b0;
      best_ver_q   <= '0;
      best_data_q  <= '0;
      clr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      req_ver_q    <= req_ver_d;
      idx_q        <= idx_d;
      best_hit_q   <= best_hit_d;
      best_ver_q   <= best_ver_d;
      best_data_q  <= best_data_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  // NOTE: slot payload is not reset; the valid bits alone decide whether it is ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ver_q[wr_idx]  <= bus.wrVersion;
      data_q[wr_idx] <= bus.wrData;
    end
  end

  assign bus.wrReady     = wr_ready;
  assign bus.rdReady     = rd_ready;
  assign bus.respValid   = (state_q == S_RESP);
  assign bus.respHit     = (state_q == S_RESP) && best_hit_q;
  assign bus.respVersion = bus.respHit ? best_ver_q  : '0;
  assign bus.respData    = bus.respHit ? best_data_q : '0;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_version_read_scheduler.sv
// Self-checking bench for version_read_scheduler: directed scenarios plus random
// transactions compared against a slot-policy model.
module tb_version_read_scheduler;

  localparam int DW = 32;
  localparam int VW = 4;
  localparam int N  = 4;

  logic clk;
  logic rstN;
  logic clear;

  version_read_scheduler_if #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW)) bus ();

  version_read_scheduler #(
    .DATA_WIDTH   (DW),
    .VERSION_WIDTH(VW),
    .VERSION_NUM  (N)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
`ifdef VERSION_SCHED_CLEAR_EN
    .clear(clear),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference store: slot contents and who won the last grant (0 = read, 1 = write).
  bit          m_valid [N];
  logic [VW-1:0] m_ver [N];
  logic [DW-1:0] m_data[N];
  bit          m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_last = 0;
  endtask

  task automatic model_write(input logic [VW-1:0] v, input logic [DW-1:0] d);
    int tgt;
    tgt = -1;
    for (int i = 0; i < N; i++)
      if (tgt < 0 && m_valid[i] && m_ver[i] == v) tgt = i;
    if (tgt < 0)
      for (int i = 0; i < N; i++)
        if (tgt < 0 && !m_valid[i]) tgt = i;
    if (tgt < 0) begin
      tgt = 0;
      for (int i = 1; i < N; i++)
        if (m_ver[i] < m_ver[tgt]) tgt = i;
    end
    m_valid[tgt] = 1;
    m_ver[tgt]   = v;
    m_data[tgt]  = d;
  endtask

  task automatic model_lookup(input logic [VW-1:0] v, output bit hit,
                              output logic [VW-1:0] ver, output logic [DW-1:0] data);
    hit  = 0;
    ver  = '0;
    data = '0;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_ver[i] <= v && (!hit || m_ver[i] > ver)) begin
        hit  = 1;
        ver  = m_ver[i];
        data = m_data[i];
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_respValid"}, bus.respValid, 0);
    check({tag, "_respHit"},   bus.respHit,   0);
    check({tag, "_respVer"},   bus.respVersion, 0);
    check({tag, "_respData"},  bus.respData,  0);
    check({tag, "_busy"},      bus.busy,      0);
  endtask

  task automatic do_reset();
    rstN          = 1'b0;
    bus.wrValid   = 1'b1;
    bus.rdValid   = 1'b1;
    bus.respReady = 1'b0;
    clear         = 1'b0;
    model_reset();
    #1;
    check_idle_outputs("reset");
    check("reset_wrReady", bus.wrReady, 0);
    check("reset_rdReady", bus.rdReady, 0);
    bus.wrValid = 1'b0;
    bus.rdValid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  // One arbitration from IDLE; a granted read is followed through scan and response.
  task automatic transact(input bit w, input bit r, input logic [VW-1:0] wv,
                          input logic [DW-1:0] wd, input logic [VW-1:0] rv,
                          input int hold, input bit clr_in_resp);
    bit gw, gr, eh;
    logic [VW-1:0] ev;
    logic [DW-1:0] ed;
    gw = w && (!r || m_last == 0);
    gr = r && !gw;
    bus.wrValid   = w;
    bus.wrVersion = wv;
    bus.wrData    = wd;
    bus.rdValid   = r;
    bus.rdVersion = rv;
    bus.respReady = 1'b0;
    #1;
    check("grant_wrReady", bus.wrReady, gw);
    check("grant_rdReady", bus.rdReady, gr);
    model_lookup(rv, eh, ev, ed);
    @(posedge clk); #1;
    bus.rdValid = 1'b0;
    if (gw) begin
      model_write(wv, wd);
      m_last = 1;
    end else if (gr) begin
      m_last = 0;
      for (int c = 1; c <= N; c++) begin
        check("scan_respValid", bus.respValid, 0);
        check("scan_wrReady",   bus.wrReady,   0);
        check("scan_busy",      bus.busy,      1);
        @(posedge clk); #1;
      end
      for (int h = 0; h <= hold; h++) begin
        check("resp_valid",   bus.respValid,   1);
        check("resp_hit",     bus.respHit,     eh);
        check("resp_version", bus.respVersion, ev);
        check("resp_data",    bus.respData,    ed);
        check("resp_wrReady", bus.wrReady,     0);
        check("resp_rdReady", bus.rdReady,     0);
        if (h < hold) begin
          if (clr_in_resp && h == 0) clear = 1'b1;
          @(posedge clk); #1;
          clear = 1'b0;
        end
      end
      bus.respReady = 1'b1;
      @(posedge clk); #1;
      bus.respReady = 1'b0;
      check("done_respValid", bus.respValid, 0);
      check("done_busy",      bus.busy,      0);
    end
    bus.wrValid = 1'b0;
  endtask

  initial begin
    rstN          = 1'b0;
    clear         = 1'b0;
    bus.wrValid   = 1'b0;
    bus.wrVersion = '0;
    bus.wrData    = '0;
    bus.rdValid   = 1'b0;
    bus.rdVersion = '0;
    bus.respReady = 1'b0;

    // Empty store: read misses with fixed latency.
    do_reset();
    transact(0, 1, 0, 0, 5, 0, 0);

    // Newest version not above the request.
    transact(1, 0, 1, 32'hAAAA_0001, 0, 0, 0);
    transact(1, 0, 3, 32'hBBBB_0003, 0, 0, 0);
    transact(1, 0, 6, 32'hCCCC_0006, 0, 0, 0);
    transact(0, 1, 0, 0, 5, 1, 0);

    // Full store evicts the oldest version.
    do_reset();
    transact(1, 0, 2, 32'h0000_0002, 0, 0, 0);
    transact(1, 0, 4, 32'h0000_0004, 0, 0, 0);
    transact(1, 0, 6, 32'h0000_0006, 0, 0, 0);
    transact(1, 0, 8, 32'h0000_0008, 0, 0, 0);
    transact(1, 0, 9, 32'hDDDD_0009, 0, 0, 0);
    transact(0, 1, 0, 0, 3, 0, 0);
    transact(0, 1, 0, 0, 9, 0, 0);
    transact(1, 0, 4, 32'h4444_FFFF, 0, 0, 0);
    transact(0, 1, 0, 0, 5, 0, 0);

    // Simultaneous requests alternate W,R,W,R from reset.
    do_reset();
    for (int k = 0; k < 4; k++) transact(1, 1, VW'(k + 7), 32'h7000 + k, 8, 0, 0);

    // Response back-pressure with a write pending.
    transact(1, 0, 5, 32'hEEEE_0005, 0, 0, 0);
    transact(1, 1, 6, 32'h6666_6666, 5, 5, 0);

    // Reset in the middle of a scan.
    bus.rdValid   = 1'b1;
    bus.rdVersion = 4'd15;
    @(posedge clk); #1;
    bus.rdValid = 1'b0;
    @(posedge clk); #1;
    check("midscan_busy", bus.busy, 1);
    do_reset();
    transact(0, 1, 0, 0, 15, 0, 0);

`ifdef VERSION_SCHED_CLEAR_EN
    // Clear during a response completes the read, then blocks one IDLE cycle.
    transact(1, 0, 3, 32'h3333_0003, 0, 0, 0);
    transact(0, 1, 0, 0, 5, 2, 1);
    bus.wrValid   = 1'b1;
    bus.wrVersion = 4'd7;
    #1;
    check("pending_clear_blocks", bus.wrReady, 0);
    @(posedge clk); #1;
    bus.wrValid = 1'b0;
    model_reset();
    transact(0, 1, 0, 0, 15, 0, 0);
    // Clear in IDLE beats both requests.
    transact(1, 0, 2, 32'h2222_0002, 0, 0, 0);
    clear       = 1'b1;
    bus.wrValid = 1'b1;
    bus.rdValid = 1'b1;
    #1;
    check("idle_clear_wrReady", bus.wrReady, 0);
    check("idle_clear_rdReady", bus.rdReady, 0);
    @(posedge clk); #1;
    clear       = 1'b0;
    bus.wrValid = 1'b0;
    bus.rdValid = 1'b0;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    transact(0, 1, 0, 0, 15, 0, 0);
`endif

    // Random mix against the reference model.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      transact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               VW'($urandom_range(0, 15)), $urandom,
               VW'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
